// File: rtl/multu_seq_pkg.sv
// Shared ALU constants: function codes, datapath width and the multiplier FSM states.
package multu_seq_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multu_seq.sv
// Sequential unsigned shift-add multiplier: one partial-product step per clock,
// WIDTH steps per operation, 2*WIDTH-bit result held in dataOut for HI/LO.
module multu_seq #(
    parameter int         WIDTH = multu_seq_pkg::WIDTH,
    parameter logic [5:0] MULTU = multu_seq_pkg::FN_MULTU
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [5:0]         Signal,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dataOut
);
    import multu_seq_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH-1:0]  prod;
    logic [CW-1:0]       cnt;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  prod_step;
    logic                accept;
    logic                last;

    assign accept = start && (Signal == MULTU);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the state register only, so there is no input-to-output path.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Upper half accumulates; the 33-bit sum keeps the carry, which shifts into bit 63.
    assign sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {sum, prod[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
            dataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= dataA;
                        prod  <= {{WIDTH{1'b0}}, dataB};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    prod <= prod_step;
                    cnt  <= cnt + CW'(1);
                    if (last) dataOut <= prod_step;
                end
                default: ;
            endcase
        end
    end

endmodule
